// File: rtl/cnn16_pkg.sv
// rtl/cnn16_pkg.sv - shared widths and responder state enumeration for the cnn16 memory slice
package cnn16_pkg;

    localparam int ADDR_W    = 12;
    localparam int DATA_W    = 16;
    localparam int MEM_DEPTH = 4096;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WRITE_ACK,
        ST_READ_WAIT,
        ST_READ_ACK
    } rsp_state_e;

endpackage

// File: rtl/cnn16_mem_responder_if.sv
// rtl/cnn16_mem_responder_if.sv - datapath-to-memory request/response bundle
interface cnn16_mem_responder_if;
    import cnn16_pkg::*;

    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] address;
    logic [DATA_W-1:0] to_memory;
    logic [DATA_W-1:0] from_memory;
    logic              mem_ack;
    logic              mem_busy;
    logic              wr_err;

    modport master (
        output mem_req, mem_we, address, to_memory,
        input  from_memory, mem_ack, mem_busy, wr_err
    );

    modport slave (
        input  mem_req, mem_we, address, to_memory,
        output from_memory, mem_ack, mem_busy, wr_err
    );

endinterface

// File: rtl/cnn16_sram_4kx16.sv
// rtl/cnn16_sram_4kx16.sv - 4096x16 synchronous single-port array, write-first, registered read
module cnn16_sram_4kx16
    import cnn16_pkg::*;
(
    input  logic              clk_i,
    input  logic              en_i,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [DATA_W-1:0] wdata_i,
    output logic [DATA_W-1:0] rdata_o
);

    logic [DATA_W-1:0] mem_q [MEM_DEPTH];
    logic [DATA_W-1:0] rdata_q;

    always_ff @(posedge clk_i) begin
        if (en_i) begin
            if (we_i) begin
                mem_q[addr_i] <= wdata_i;
                rdata_q       <= wdata_i;
            end else begin
                rdata_q       <= mem_q[addr_i];
            end
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/cnn16_mem_responder.sv
// rtl/cnn16_mem_responder.sv - single-outstanding memory responder with fixed read latency
// Optional write protection below WPROT_LIMIT is enabled by CNN16_MEM_WPROT_EN.
module cnn16_mem_responder
    import cnn16_pkg::*;
#(
    parameter int unsigned       READ_LAT    = 2,
    parameter logic [ADDR_W-1:0] WPROT_LIMIT = 12'h100
) (
    input  logic                  clk,
    input  logic                  rst,
    cnn16_mem_responder_if.slave  bus
);

    rsp_state_e        state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              ack_q, ack_d;
    logic              busy_q, busy_d;
    logic              err_q, err_d;
    logic [DATA_W-1:0] hold_q, hold_d;

    logic              sram_en;
    logic              sram_we;
    logic [ADDR_W-1:0] sram_addr;
    logic [DATA_W-1:0] sram_rdata;
    logic              wr_block;

`ifdef CNN16_MEM_WPROT_EN
    assign wr_block = (bus.address < WPROT_LIMIT);
`else
    logic unused_wprot;
    assign wr_block     = 1'b0;
    assign unused_wprot = ^WPROT_LIMIT;
`endif

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        addr_d    = addr_q;
        err_d     = 1'b0;
        hold_d    = hold_q;
        sram_en   = 1'b0;
        sram_we   = 1'b0;
        sram_addr = addr_q;

        unique case (state_q)
            ST_IDLE: begin
                if (bus.mem_req) begin
                    addr_d    = bus.address;
                    sram_addr = bus.address;
                    if (bus.mem_we) begin
                        state_d = ST_WRITE_ACK;
                        sram_en = !wr_block;
                        sram_we = 1'b1;
                        err_d   = wr_block;
                    end else if (READ_LAT == 1) begin
                        state_d = ST_READ_ACK;
                        sram_en = 1'b1;
                    end else begin
                        state_d = ST_READ_WAIT;
                        cnt_d   = 4'(READ_LAT - 1);
                    end
                end
            end
            ST_WRITE_ACK: state_d = ST_IDLE;
            ST_READ_WAIT: begin
                // The array read is launched on the last wait edge so its
                // registered output lines up with the ack cycle.
                if (cnt_q == 4'd1) begin
                    state_d = ST_READ_ACK;
                    cnt_d   = 4'd0;
                    sram_en = 1'b1;
                end else begin
                    cnt_d   = cnt_q - 4'd1;
                end
            end
            ST_READ_ACK: begin
                state_d = ST_IDLE;
                hold_d  = sram_rdata;
            end
            default: state_d = ST_IDLE;
        endcase

        if (rst) begin
            sram_en = 1'b0;
        end

        ack_d  = (state_d == ST_WRITE_ACK) || (state_d == ST_READ_ACK);
        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            ack_q   <= 1'b0;
            busy_q  <= 1'b0;
            err_q   <= 1'b0;
            hold_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            ack_q   <= ack_d;
            busy_q  <= busy_d;
            err_q   <= err_d;
            hold_q  <= hold_d;
        end
    end

    cnn16_sram_4kx16 u_sram (
        .clk_i   (clk),
        .en_i    (sram_en),
        .we_i    (sram_we),
        .addr_i  (sram_addr),
        .wdata_i (bus.to_memory),
        .rdata_o (sram_rdata)
    );

    // Array output is only shown in the ack cycle; otherwise the held word,
    // so writes that update the array read register never leak out.
    assign bus.from_memory = (state_q == ST_READ_ACK) ? sram_rdata : hold_q;
    assign bus.mem_ack     = ack_q;
    assign bus.mem_busy    = busy_q;
    assign bus.wr_err      = err_q;

endmodule

// File: tb/tb_cnn16_mem_responder.sv
// tb/tb_cnn16_mem_responder.sv - table, corner-sequence and random checks over five read latencies
module tb_cnn16_mem_responder;
    import cnn16_pkg::*;

    localparam int NI = 5;

    function automatic int lat_of(input int k);
        case (k)
            0:       return 1;
            1:       return 2;
            2:       return 4;
            3:       return 5;
            default: return 15;
        endcase
    endfunction

    function automatic bit prot(input logic [11:0] a);
`ifdef CNN16_MEM_WPROT_EN
        return (a < 12'h100);
`else
        return (a != a);
`endif
    endfunction

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_v  [NI];
    logic        req_v  [NI];
    logic        we_v   [NI];
    logic [11:0] addr_v [NI];
    logic [15:0] wd_v   [NI];
    logic [15:0] rd_v   [NI];
    logic        ack_v  [NI];
    logic        busy_v [NI];
    logic        err_v  [NI];

    int          checks = 0;
    int          errors = 0;
    logic [15:0] mdl [int];
    logic [15:0] last_rd [NI];
    bit          last_known [NI];

    for (genvar k = 0; k < NI; k++) begin : g_dut
        cnn16_mem_responder_if u_if ();
        assign u_if.mem_req   = req_v[k];
        assign u_if.mem_we    = we_v[k];
        assign u_if.address   = addr_v[k];
        assign u_if.to_memory = wd_v[k];
        assign rd_v[k]        = u_if.from_memory;
        assign ack_v[k]       = u_if.mem_ack;
        assign busy_v[k]      = u_if.mem_busy;
        assign err_v[k]       = u_if.wr_err;

        cnn16_mem_responder #(.READ_LAT(lat_of(k))) u_dut (
            .clk (clk),
            .rst (rst_v[k]),
            .bus (u_if)
        );
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Issue one request from a negedge and follow it to completion.
    task automatic do_txn(input int k, input bit we, input logic [11:0] a, input logic [15:0] d,
                          output logic [15:0] rd, output int lat, output bit err);
        int key;
        key = k * 4096 + int'(a);
        req_v[k] = 1'b1; we_v[k] = we; addr_v[k] = a; wd_v[k] = d;
        @(negedge clk);
        req_v[k] = 1'b0;
        lat = 0; err = 1'b0; rd = '0;
        for (int i = 1; i <= 40; i++) begin
            if (ack_v[k]) begin
                lat = i; rd = rd_v[k]; err = err_v[k];
                chk($sformatf("busy_at_ack_k%0d", k), 32'(busy_v[k]), 1);
                if (we && last_known[k]) chk($sformatf("rd_hold_k%0d", k), 32'(rd), 32'(last_rd[k]));
                break;
            end
            chk($sformatf("busy_wait_k%0d", k), 32'(busy_v[k]), 1);
            chk($sformatf("err_no_ack_k%0d", k), 32'(err_v[k]), 0);
            @(negedge clk);
        end
        if (lat == 0) chk($sformatf("ack_timeout_k%0d", k), 0, 1);
        @(negedge clk);
        chk($sformatf("ack_single_k%0d", k), 32'(ack_v[k]), 0);
        chk($sformatf("busy_clear_k%0d", k), 32'(busy_v[k]), 0);
        if (!we) begin
            last_known[k] = mdl.exists(key);
            if (last_known[k]) last_rd[k] = mdl[key];
        end else if (!prot(a)) begin
            mdl[key] = d;
        end
    endtask

    typedef struct {
        int          k;
        bit          we;
        logic [11:0] a;
        logic [15:0] d;
        bit          cd;
        logic [15:0] ed;
        int          el;
        bit          ee;
    } vec_t;

    function automatic vec_t mk(input int k, input bit we, input logic [11:0] a,
                                input logic [15:0] d, input bit ee);
        vec_t v;
        v.k = k; v.we = we; v.a = a; v.d = we ? d : 16'h0;
        v.cd = !we; v.ed = d; v.el = we ? 1 : lat_of(k); v.ee = ee;
        return v;
    endfunction

    initial begin
        vec_t        tbl[$];
        logic [15:0] rd, d1, d2, v0;
        int          lat, acks, first, second, key;
        bit          err, we;
        logic [11:0] a;
        logic [15:0] d;
        logic [11:0] pool [5];

        tbl.push_back(mk(1, 1, 12'h200, 16'hBEEF, 0));
        tbl.push_back(mk(1, 0, 12'h200, 16'hBEEF, 0));
        tbl.push_back(mk(0, 1, 12'hFFF, 16'h1234, 0));
        tbl.push_back(mk(0, 0, 12'hFFF, 16'h1234, 0));
        tbl.push_back(mk(4, 1, 12'hFFF, 16'h1234, 0));
        tbl.push_back(mk(4, 0, 12'hFFF, 16'h1234, 0));
        tbl.push_back(mk(2, 1, 12'h010, 16'h5A5A, 0));
        tbl.push_back(mk(3, 1, 12'h300, 16'hA5A5, 0));
        tbl.push_back(mk(3, 0, 12'h300, 16'hA5A5, 0));
`ifndef CNN16_MEM_WPROT_EN
        tbl.push_back(mk(1, 1, 12'h0FF, 16'h0001, 0));
        tbl.push_back(mk(1, 1, 12'h0FF, 16'hFFFF, 0));
        tbl.push_back(mk(1, 0, 12'h0FF, 16'hFFFF, 0));
`endif
        tbl.push_back(mk(1, 1, 12'h100, 16'hCAFE, 0));
        tbl.push_back(mk(1, 0, 12'h100, 16'hCAFE, 0));

        for (int k = 0; k < NI; k++) begin
            rst_v[k] = 1'b1; req_v[k] = 1'b0; we_v[k] = 1'b0;
            addr_v[k] = '0; wd_v[k] = '0; last_rd[k] = '0; last_known[k] = 1'b1;
        end
        repeat (3) @(negedge clk);
        for (int k = 0; k < NI; k++) begin
            chk($sformatf("rst_ack_k%0d", k), 32'(ack_v[k]), 0);
            chk($sformatf("rst_busy_k%0d", k), 32'(busy_v[k]), 0);
            chk($sformatf("rst_err_k%0d", k), 32'(err_v[k]), 0);
            chk($sformatf("rst_rd_k%0d", k), 32'(rd_v[k]), 0);
            rst_v[k] = 1'b0;
        end
        @(negedge clk);

        for (int i = 0; i < tbl.size(); i++) begin
            do_txn(tbl[i].k, tbl[i].we, tbl[i].a, tbl[i].d, rd, lat, err);
            chk($sformatf("vec%0d_lat", i), lat, tbl[i].el);
            chk($sformatf("vec%0d_err", i), 32'(err), 32'(tbl[i].ee));
            if (tbl[i].cd) chk($sformatf("vec%0d_data", i), 32'(rd), 32'(tbl[i].ed));
        end

`ifdef CNN16_MEM_WPROT_EN
        do_txn(1, 0, 12'h0FF, 16'h0, v0, lat, err);
        do_txn(1, 1, 12'h0FF, 16'hFFFF, rd, lat, err);
        chk("wprot_err", 32'(err), 1);
        chk("wprot_lat", lat, 1);
        do_txn(1, 0, 12'h0FF, 16'h0, rd, lat, err);
        chk("wprot_unchanged", 32'(rd), 32'(v0));
`endif

        // Requests held high through a LAT=4 read must be ignored until idle.
        req_v[2] = 1'b1; we_v[2] = 1'b0; addr_v[2] = 12'h010;
        @(negedge clk);
        we_v[2] = 1'b1; wd_v[2] = 16'hDEAD;
        acks = 0; first = 0; second = 0; d1 = '0; d2 = '0;
        for (int i = 1; i <= 20; i++) begin
            if (ack_v[2]) begin
                acks++;
                if (acks == 1) begin first = i; d1 = rd_v[2]; we_v[2] = 1'b0; end
                else begin second = i; d2 = rd_v[2]; end
            end
            if (first > 0 && i == first + 1) chk("hold_req_idle_after_ack", 32'(busy_v[2]), 0);
            if (first > 0 && i == first + 2) begin
                chk("hold_req_reaccept", 32'(busy_v[2]), 1);
                req_v[2] = 1'b0;
            end
            @(negedge clk);
        end
        chk("hold_req_first_ack", first, 4);
        chk("hold_req_second_ack", second, 9);
        chk("hold_req_ack_count", acks, 2);
        chk("hold_req_data1", 32'(d1), 32'h5A5A);
        chk("hold_req_data2", 32'(d2), 32'h5A5A);
        last_rd[2] = 16'h5A5A; last_known[2] = 1'b1;

        // Reset two cycles into a LAT=5 read aborts it; earlier write survives.
        req_v[3] = 1'b1; we_v[3] = 1'b0; addr_v[3] = 12'h300;
        @(negedge clk);
        req_v[3] = 1'b0;
        @(negedge clk);
        rst_v[3] = 1'b1;
        @(negedge clk);
        rst_v[3] = 1'b0;
        chk("abort_ack", 32'(ack_v[3]), 0);
        chk("abort_busy", 32'(busy_v[3]), 0);
        chk("abort_rd", 32'(rd_v[3]), 0);
        acks = 0;
        for (int i = 0; i < 10; i++) begin
            if (ack_v[3]) acks++;
            @(negedge clk);
        end
        chk("abort_no_ack", acks, 0);
        last_rd[3] = '0; last_known[3] = 1'b1;
        do_txn(3, 0, 12'h300, 16'h0, rd, lat, err);
        chk("abort_readback", 32'(rd), 32'hA5A5);
        chk("abort_readback_lat", lat, 5);

        pool[0] = 12'h000; pool[1] = 12'h0FF; pool[2] = 12'h100;
        pool[3] = 12'h2AB; pool[4] = 12'hFFF;
        for (int n = 0; n < 80; n++) begin
            int k;
            k  = $urandom_range(0, NI - 1);
            we = 1'($urandom_range(0, 1));
            a  = ($urandom_range(0, 5) == 5) ? 12'($urandom_range(0, 4095)) : pool[$urandom_range(0, 4)];
            d  = 16'($urandom);
            key = k * 4096 + int'(a);
            do_txn(k, we, a, d, rd, lat, err);
            chk($sformatf("rnd%0d_lat", n), lat, we ? 1 : lat_of(k));
            chk($sformatf("rnd%0d_err", n), 32'(err), 32'(we && prot(a)));
            if (!we && mdl.exists(key)) chk($sformatf("rnd%0d_data", n), 32'(rd), 32'(mdl[key]));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

endmodule
